// File: rtl/sm_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_dbg_pkg
// Description : Shared types and constants for the schoolMIPS debug controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sm_dbg_pkg;

    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        OP_HALT = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_SCAN = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_SCAN = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sm_dbg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sm_dbg_ctrl_if
// Description : Command, core-control and scan-stream bundle of the debug
//               controller; master = board side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sm_dbg_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CNT_W-1:0]  cmd_arg;
    logic              cmd_err;
    logic              cpu_tick;
    logic              clkEnable;
    logic [ADDR_W-1:0] manual_addr;
    logic [ADDR_W-1:0] regAddr;
    logic [DATA_W-1:0] regData;
    logic              scan_valid;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cpu_tick, manual_addr, regData,
        input  cmd_ready, cmd_err, clkEnable, regAddr, scan_valid, scan_addr,
               scan_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cpu_tick, manual_addr, regData,
        output cmd_ready, cmd_err, clkEnable, regAddr, scan_valid, scan_addr,
               scan_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/sm_dbg_scan.sv
`default_nettype none
// ============================================================================
// Module      : sm_dbg_scan
// Description : Register-file address walker; holds each address SETTLE
//               cycles, then flags one capture cycle before advancing.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_dbg_scan
    import sm_dbg_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_capture,
    output logic              o_done
);
    localparam int                SET_W         = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0]  c_settle_last = SET_W'(SETTLE);
    localparam logic [ADDR_W-1:0] c_last_addr   = ADDR_W'(NUM_REGS - 1);

    logic              r_active;
    logic [ADDR_W-1:0] r_ptr;
    logic [SET_W-1:0]  r_settle;

    assign o_ptr     = r_ptr;
    assign o_capture = r_active && (r_settle == c_settle_last);
    assign o_done    = o_capture && (r_ptr == c_last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_ptr    <= '0;
            r_settle <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_ptr    <= '0;
            r_settle <= '0;
        end else if (o_capture) begin
            // Pointer rolls 31 -> 0 on the final capture, leaving it ready for the next scan.
            r_settle <= '0;
            r_ptr    <= r_ptr + ADDR_W'(1);
            r_active <= !o_done;
        end else if (r_active) begin
            r_settle <= r_settle + SET_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm_dbg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sm_dbg_ctrl
// Description : schoolMIPS debug run-control (HALT/RUN/STEP-N) and halted
//               register-file scan streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_dbg_ctrl
    import sm_dbg_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic         clkIn,
    input  logic         rst_p,
    sm_dbg_ctrl_if.slave bus
);
    state_e            r_state;
    logic              r_clk_en;
    logic              r_cmd_ready;
    logic              r_cmd_err;
    logic              r_busy;
    logic              r_scan_valid;
    logic [ADDR_W-1:0] r_scan_addr;
    logic [DATA_W-1:0] r_scan_data;
    logic [CNT_W-1:0]  r_step_cnt;

    cmd_op_e           w_op;
    logic              w_accept;
    logic              w_start;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_capture;
    logic              w_done;

    assign w_op     = cmd_op_e'(bus.cmd_op);
    assign w_accept = bus.cmd_valid && r_cmd_ready;
    assign w_start  = w_accept && (r_state == ST_HALT) && (w_op == OP_SCAN);

    sm_dbg_scan #(
        .ADDR_W (ADDR_W),
        .SETTLE (SETTLE)
    ) u_scan (
        .clk       (clkIn),
        .rst       (rst_p),
        .i_start   (w_start),
        .o_ptr     (w_ptr),
        .o_capture (w_capture),
        .o_done    (w_done)
    );

    assign bus.regAddr    = (r_state == ST_SCAN) ? w_ptr : bus.manual_addr;
    assign bus.clkEnable  = r_clk_en;
    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.cmd_err    = r_cmd_err;
    assign bus.busy       = r_busy;
    assign bus.scan_valid = r_scan_valid;
    assign bus.scan_addr  = r_scan_addr;
    assign bus.scan_data  = r_scan_data;

    always_ff @(posedge clkIn) begin
        if (rst_p) begin
            r_state      <= ST_HALT;
            r_clk_en     <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_cmd_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_scan_valid <= 1'b0;
            r_scan_addr  <= '0;
            r_scan_data  <= '0;
            r_step_cnt   <= '0;
        end else begin
            r_cmd_err    <= 1'b0;
            r_scan_valid <= 1'b0;
            if (w_capture) begin
                r_scan_valid <= 1'b1;
                r_scan_addr  <= w_ptr;
                r_scan_data  <= bus.regData;
            end
            case (r_state)
                ST_HALT: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_RUN: begin
                                r_state  <= ST_RUN;
                                r_clk_en <= 1'b1;
                            end
                            OP_STEP: begin
                                // A zero-length step is a silent no-op.
                                if (bus.cmd_arg != '0) begin
                                    r_state     <= ST_STEP;
                                    r_step_cnt  <= bus.cmd_arg;
                                    r_clk_en    <= 1'b1;
                                    r_busy      <= 1'b1;
                                    r_cmd_ready <= 1'b0;
                                end
                            end
                            OP_SCAN: begin
                                r_state     <= ST_SCAN;
                                r_busy      <= 1'b1;
                                r_cmd_ready <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_HALT: begin
                                r_state  <= ST_HALT;
                                r_clk_en <= 1'b0;
                            end
                            OP_STEP, OP_SCAN: r_cmd_err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_STEP: begin
                    if (bus.cpu_tick && (r_step_cnt != '0)) begin
                        r_step_cnt <= r_step_cnt - CNT_W'(1);
                        if (r_step_cnt == CNT_W'(1)) begin
                            r_state     <= ST_HALT;
                            r_clk_en    <= 1'b0;
                            r_busy      <= 1'b0;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_done) begin
                        r_state     <= ST_HALT;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_dbg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_dbg_ctrl
// Description : Directed plus randomized bench for sm_dbg_ctrl against a
//               behavioural run-control / scan-timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_dbg_ctrl;
    import sm_dbg_pkg::*;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 16;
    localparam int SETTLE   = 2;
    localparam int HOLD     = SETTLE + 1;
    localparam int SCAN_LEN = NUM_REGS * HOLD;
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_SCAN = 3;

    logic clk   = 1'b0;
    logic rst_p = 1'b1;
    always #5 clk = ~clk;

    sm_dbg_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sm_dbg_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .SETTLE (SETTLE)
    ) dut (
        .clkIn (clk),
        .rst_p (rst_p),
        .bus   (bus)
    );

    logic [DATA_W-1:0] regfile [NUM_REGS];
    assign bus.regData = regfile[bus.regAddr];

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int tick_mode = 0;
    int en_ticks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Behavioural model: mode, steps remaining, and elapsed cycles of the current scan.
    int                m_mode = M_HALT;
    int                m_left = 0;
    int                m_t    = 0;
    int                m_k    = 0;
    bit                m_acc  = 0;
    bit                m_live = 0;
    bit                m_err  = 0;
    bit                m_sv   = 0;
    logic [ADDR_W-1:0] m_sa   = '0;
    logic [DATA_W-1:0] m_sd   = '0;

    always @(posedge clk) begin
        if (rst_p) begin
            m_mode = M_HALT; m_left = 0; m_t = 0;
            m_err = 0; m_sv = 0; m_sa = '0; m_sd = '0;
            m_live = 1;
        end else if (m_live) begin
            m_acc = bus.cmd_valid && (m_mode == M_HALT || m_mode == M_RUN);
            m_err = 0;
            m_sv  = 0;
            case (m_mode)
                M_HALT: if (m_acc) begin
                    if (bus.cmd_op == OP_RUN) m_mode = M_RUN;
                    else if (bus.cmd_op == OP_STEP && bus.cmd_arg != 0) begin
                        m_mode = M_STEP; m_left = int'(bus.cmd_arg);
                    end else if (bus.cmd_op == OP_SCAN) begin
                        m_mode = M_SCAN; m_t = 1;
                    end
                end
                M_RUN: if (m_acc) begin
                    if (bus.cmd_op == OP_HALT) m_mode = M_HALT;
                    else if (bus.cmd_op == OP_STEP || bus.cmd_op == OP_SCAN) m_err = 1;
                end
                M_STEP: if (bus.cpu_tick) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_HALT;
                end
                default: begin
                    m_t++;
                    if (m_t >= HOLD + 1 && (m_t - 1) % HOLD == 0) begin
                        m_k  = (m_t - 1) / HOLD - 1;
                        m_sv = 1;
                        m_sa = ADDR_W'(m_k);
                        m_sd = regfile[m_k];
                    end
                    if (m_t == SCAN_LEN + 1) m_mode = M_HALT;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            chk("clkEnable", 64'(bus.clkEnable), 64'(m_mode == M_RUN || m_mode == M_STEP));
            chk("cmd_ready", 64'(bus.cmd_ready), 64'(m_mode == M_HALT || m_mode == M_RUN));
            chk("busy", 64'(bus.busy), 64'(m_mode == M_STEP || m_mode == M_SCAN));
            chk("cmd_err", 64'(bus.cmd_err), 64'(m_err));
            chk("scan_valid", 64'(bus.scan_valid), 64'(m_sv));
            chk("scan_addr", 64'(bus.scan_addr), 64'(m_sa));
            chk("scan_data", 64'(bus.scan_data), 64'(m_sd));
            chk("regAddr", 64'(bus.regAddr),
                (m_mode == M_SCAN) ? 64'((m_t - 1) / HOLD) : 64'(bus.manual_addr));
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        cyc_n++;
        bus.cmd_valid = 1'b0;
        case (tick_mode)
            0:       bus.cpu_tick = 1'b0;
            1:       bus.cpu_tick = (cyc_n % 4 == 0);
            default: bus.cpu_tick = ($urandom_range(0, 2) == 0);
        endcase
        if (bus.cpu_tick && bus.clkEnable) en_ticks++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] arg);
        next_cycle();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
    endtask

    task automatic wait_ready(input int limit, input string name);
        int n = 0;
        while (!bus.cmd_ready && n < limit) begin
            next_cycle();
            n++;
        end
        chk(name, 64'(bus.cmd_ready), 64'd1);
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!bus.scan_valid && n < limit) begin
            next_cycle();
            n++;
        end
    endtask

    initial begin
        int n_valid;
        int last;
        int acc_cyc;
        int guard;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'b00;
        bus.cmd_arg     = '0;
        bus.cpu_tick    = 1'b0;
        bus.manual_addr = 5'd7;
        for (int i = 0; i < NUM_REGS; i++) regfile[i] = DATA_W'(i) * 32'h01010101;

        // Reset and idle
        repeat (3) next_cycle();
        rst_p = 1'b0;
        chk("rst_clkEnable", 64'(bus.clkEnable), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_scan_valid", 64'(bus.scan_valid), 64'd0);
        chk("rst_scan_addr", 64'(bus.scan_addr), 64'd0);
        chk("rst_scan_data", 64'(bus.scan_data), 64'd0);
        chk("idle_regAddr", 64'(bus.regAddr), 64'd7);

        // RUN, illegal SCAN while running, HALT
        tick_mode = 1;
        issue(OP_RUN, '0);
        next_cycle();
        chk("run_clkEnable", 64'(bus.clkEnable), 64'd1);
        issue(OP_SCAN, '0);
        next_cycle();
        chk("run_scan_err", 64'(bus.cmd_err), 64'd1);
        chk("run_scan_stays", 64'(bus.clkEnable), 64'd1);
        next_cycle();
        chk("run_err_pulse", 64'(bus.cmd_err), 64'd0);
        issue(OP_HALT, '0);
        next_cycle();
        chk("halt_clkEnable", 64'(bus.clkEnable), 64'd0);

        // STEP 5 with a command attempted mid-step
        en_ticks = 0;
        issue(OP_STEP, 16'd5);
        next_cycle();
        chk("step_busy", 64'(bus.busy), 64'd1);
        chk("step_ready", 64'(bus.cmd_ready), 64'd0);
        chk("step_clkEnable", 64'(bus.clkEnable), 64'd1);
        next_cycle();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_HALT;
        wait_ready(200, "step_timeout");
        chk("step_ticks", 64'(en_ticks), 64'd5);

        // STEP 0 is a no-op
        issue(OP_STEP, '0);
        next_cycle();
        chk("step0_busy", 64'(bus.busy), 64'd0);
        chk("step0_clkEnable", 64'(bus.clkEnable), 64'd0);
        chk("step0_err", 64'(bus.cmd_err), 64'd0);

        // Full scan of the i*0x01010101 register file
        tick_mode = 0;
        issue(OP_SCAN, '0);
        acc_cyc = cyc_n;
        n_valid = 0;
        last    = 0;
        guard   = 0;
        while (n_valid < NUM_REGS && guard < 400) begin
            next_cycle();
            guard++;
            if (bus.scan_valid) begin
                if (n_valid > 0) chk("scan_gap", 64'(cyc_n - last), 64'd3);
                chk("scan_addr_seq", 64'(bus.scan_addr), 64'(n_valid));
                chk("scan_data_seq", 64'(bus.scan_data), 64'(DATA_W'(n_valid) * 32'h01010101));
                last = cyc_n;
                n_valid++;
            end
        end
        chk("scan_count", 64'(n_valid), 64'd32);
        chk("scan_total", 64'(last - acc_cyc - 1), 64'd96);
        chk("scan_ready_last", 64'(bus.cmd_ready), 64'd1);

        // Reset in the middle of a scan, then restart
        issue(OP_SCAN, '0);
        guard = 0;
        while (!(bus.scan_valid && bus.scan_addr == 5'd10) && guard < 200) begin
            next_cycle();
            guard++;
        end
        chk("mid_scan_addr10", 64'(bus.scan_addr), 64'd10);
        rst_p = 1'b1;
        bus.manual_addr = 5'd19;
        next_cycle();
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_scan_valid", 64'(bus.scan_valid), 64'd0);
        chk("midrst_regAddr", 64'(bus.regAddr), 64'd19);
        chk("midrst_ready", 64'(bus.cmd_ready), 64'd1);
        rst_p = 1'b0;
        issue(OP_SCAN, '0);
        next_cycle();
        wait_valid(20);
        chk("rescan_first_addr", 64'(bus.scan_addr), 64'd0);
        chk("rescan_first_valid", 64'(bus.scan_valid), 64'd1);
        wait_ready(200, "rescan_timeout");

        // Randomized traffic against the model
        tick_mode = 2;
        repeat (3000) begin
            next_cycle();
            bus.manual_addr = ADDR_W'($urandom);
            if ($urandom_range(0, 7) == 0) regfile[$urandom_range(0, NUM_REGS - 1)] = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'($urandom);
                bus.cmd_arg   = CNT_W'($urandom_range(0, 6));
            end
            rst_p = ($urandom_range(0, 299) == 0);
        end
        rst_p = 1'b0;
        repeat (2) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
